rs_issue_sched: RTL

RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

---
 rtl/rs_issue_sched.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rs_issue_sched.sv
// Five-slot reservation-station issue scheduler: ALU/LD/ST slots plus two MUL slots sharing one port.
// Optional statistics counters are built only when RS_SCHED_STATS_EN is defined.
module rs_issue_sched #(
   parameter int TAG_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             squash,
   input  logic             alloc_valid,
   input  logic [2:0]       alloc_slot,
   input  logic [TAG_W-1:0] alloc_T,
   input  logic [TAG_W-1:0] alloc_T1,
   input  logic [TAG_W-1:0] alloc_T2,
   input  logic             alloc_r1,
   input  logic             alloc_r2,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   output logic [4:0]       busy,
   output logic             alu_iss_valid,
   input  logic             alu_iss_ready,
   output logic [TAG_W-1:0] alu_iss_T,
   output logic [TAG_W-1:0] alu_iss_T1,
   output logic [TAG_W-1:0] alu_iss_T2,
   output logic             ld_iss_valid,
   input  logic             ld_iss_ready,
   output logic [TAG_W-1:0] ld_iss_T,
   output logic [TAG_W-1:0] ld_iss_T1,
   output logic [TAG_W-1:0] ld_iss_T2,
   output logic             st_iss_valid,
   input  logic             st_iss_ready,
   output logic [TAG_W-1:0] st_iss_T,
   output logic [TAG_W-1:0] st_iss_T1,
   output logic [TAG_W-1:0] st_iss_T2,
   output logic             mul_iss_valid,
   input  logic             mul_iss_ready,
   output logic [TAG_W-1:0] mul_iss_T,
   output logic [TAG_W-1:0] mul_iss_T1,
   output logic [TAG_W-1:0] mul_iss_T2,
   output logic             mul_iss_slot,
   output logic [31:0]      issue_count,
   output logic [31:0]      mul_conflict_count
);

   typedef enum logic [1:0] {
      S_FREE  = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } slot_state_e;

   slot_state_e      state_q [5];
   slot_state_e      state_d [5];
   logic [TAG_W-1:0] t_q  [5];
   logic [TAG_W-1:0] t_d  [5];
   logic [TAG_W-1:0] t1_q [5];
   logic [TAG_W-1:0] t1_d [5];
   logic [TAG_W-1:0] t2_q [5];
   logic [TAG_W-1:0] t2_d [5];
   logic [4:0]       rdy1_q, rdy1_d;
   logic [4:0]       rdy2_q, rdy2_d;
   logic             rr_q, rr_d;
   logic [4:0]       ready_s;
   logic [4:0]       hs_s;
   logic             mul_sel_s;

   // Slot status decode, MUL arbitration and issue handshakes.
   always_comb begin
      ready_s = 5'd0;
      busy    = 5'd0;
      for (int i = 0; i < 5; i++) begin
         ready_s[i] = (state_q[i] == S_READY);
         busy[i]    = (state_q[i] != S_FREE);
      end
      // rr_q = 1 gives slot 4 priority when both MUL slots are ready.
      mul_sel_s = ready_s[4] & (~ready_s[3] | rr_q);
      hs_s[0]   = ready_s[0] & alu_iss_ready;
      hs_s[1]   = ready_s[1] & ld_iss_ready;
      hs_s[2]   = ready_s[2] & st_iss_ready;
      hs_s[3]   = ready_s[3] & ~mul_sel_s & mul_iss_ready;
      hs_s[4]   = ready_s[4] &  mul_sel_s & mul_iss_ready;
   end

   // Issue port outputs driven straight from the slot registers.
   always_comb begin
      alu_iss_valid = ready_s[0];
      alu_iss_T     = t_q[0];
      alu_iss_T1    = t1_q[0];
      alu_iss_T2    = t2_q[0];
      ld_iss_valid  = ready_s[1];
      ld_iss_T      = t_q[1];
      ld_iss_T1     = t1_q[1];
      ld_iss_T2     = t2_q[1];
      st_iss_valid  = ready_s[2];
      st_iss_T      = t_q[2];
      st_iss_T1     = t1_q[2];
      st_iss_T2     = t2_q[2];
      mul_iss_valid = ready_s[3] | ready_s[4];
      mul_iss_slot  = mul_sel_s;
      if (mul_sel_s) begin
         mul_iss_T  = t_q[4];
         mul_iss_T1 = t1_q[4];
         mul_iss_T2 = t2_q[4];
      end else begin
         mul_iss_T  = t_q[3];
         mul_iss_T1 = t1_q[3];
         mul_iss_T2 = t2_q[3];
      end
   end

   // Per-slot next state: allocation with CDB bypass, wakeup, issue and squash.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      rdy1_d  = rdy1_q;
      rdy2_d  = rdy2_q;
      rr_d    = rr_q;
      if ((ready_s[3] | ready_s[4]) && mul_iss_ready) begin
         rr_d = ~mul_sel_s;
      end else begin
         rr_d = rr_q;
      end
      for (int i = 0; i < 5; i++) begin
         if (squash) begin
            state_d[i] = S_FREE;
            rdy1_d[i]  = 1'b0;
            rdy2_d[i]  = 1'b0;
         end else begin
            case (state_q[i])
               S_FREE: begin
                  if (alloc_valid && (alloc_slot == 3'(i))) begin
                     t_d[i]     = alloc_T;
                     t1_d[i]    = alloc_T1;
                     t2_d[i]    = alloc_T2;
                     rdy1_d[i]  = alloc_r1 | (cdb_valid && (cdb_tag == alloc_T1));
                     rdy2_d[i]  = alloc_r2 | (cdb_valid && (cdb_tag == alloc_T2));
                     state_d[i] = (rdy1_d[i] && rdy2_d[i]) ? S_READY : S_WAIT;
                  end else begin
                     state_d[i] = S_FREE;
                  end
               end
               S_WAIT: begin
                  rdy1_d[i]  = rdy1_q[i] | (cdb_valid && (cdb_tag == t1_q[i]));
                  rdy2_d[i]  = rdy2_q[i] | (cdb_valid && (cdb_tag == t2_q[i]));
                  state_d[i] = (rdy1_d[i] && rdy2_d[i]) ? S_READY : S_WAIT;
               end
               S_READY: begin
                  if (hs_s[i]) begin
                     state_d[i] = S_FREE;
                     rdy1_d[i]  = 1'b0;
                     rdy2_d[i]  = 1'b0;
                  end else begin
                     state_d[i] = S_READY;
                  end
               end
               default: begin
                  state_d[i] = S_FREE;
                  rdy1_d[i]  = 1'b0;
                  rdy2_d[i]  = 1'b0;
               end
            endcase
         end
      end
   end

   // Slot and round-robin state registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 5; i++) begin
            state_q[i] <= S_FREE;
            t_q[i]     <= {TAG_W{1'b0}};
            t1_q[i]    <= {TAG_W{1'b0}};
            t2_q[i]    <= {TAG_W{1'b0}};
         end
         rdy1_q <= 5'd0;
         rdy2_q <= 5'd0;
         rr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
         rdy1_q  <= rdy1_d;
         rdy2_q  <= rdy2_d;
         rr_q    <= rr_d;
      end
   end

`ifdef RS_SCHED_STATS_EN
   logic [31:0] issue_count_q, issue_count_d;
   logic [31:0] mul_conflict_count_q, mul_conflict_count_d;

   // Statistics: handshakes per cycle and cycles with both MUL slots ready.
   always_comb begin
      issue_count_d = issue_count_q + 32'($countones(hs_s));
      if (ready_s[3] && ready_s[4]) begin
         mul_conflict_count_d = mul_conflict_count_q + 32'd1;
      end else begin
         mul_conflict_count_d = mul_conflict_count_q;
      end
   end

   // Statistics registers; squash deliberately leaves them untouched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         issue_count_q        <= 32'd0;
         mul_conflict_count_q <= 32'd0;
      end else begin
         issue_count_q        <= issue_count_d;
         mul_conflict_count_q <= mul_conflict_count_d;
      end
   end

   assign issue_count        = issue_count_q;
   assign mul_conflict_count = mul_conflict_count_q;
`else
   assign issue_count        = 32'd0;
   assign mul_conflict_count = 32'd0;
`endif

endmodule
